// File: rtl/input_control_pkg.sv
// input_control_pkg: shared FSM states, operator codes and one-cold column drive values.
package input_control_pkg;
  typedef enum logic [2:0] {SCAN, DEB_PRESS, WAIT_REL, DEB_REL, READY} state_e;
  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;
  localparam logic [3:0] COL0 = 4'b0111;
  localparam logic [3:0] COL1 = 4'b1011;
  localparam logic [3:0] COL2 = 4'b1101;
  localparam logic [3:0] COL3 = 4'b1110;
  // Index of the lowest-numbered active-low line; bit 3 is index 0.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    return !v[3] ? 2'd0 : !v[2] ? 2'd1 : !v[1] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/input_control_keypad_decode.sv
// keypad_decode: combinational (row, col) to Number/Operator/EqualSign for the 4x4 calculator keypad.
module keypad_decode
  import input_control_pkg::*;
(
  input  logic [1:0] row_i,
  input  logic [1:0] col_i,
  output logic [3:0] number_o,
  output logic [2:0] operator_o,
  output logic       equal_o
);
  always_comb begin
    number_o = '0;
    operator_o = OP_NONE;
    equal_o = 1'b0;
    // Right column holds + - * / from top (row 3) to bottom (row 0).
    if (col_i == 2'd3) operator_o = 3'd4 - {1'b0, row_i};
    else if (row_i != 2'd0) number_o = 4'd3 * (4'd3 - {2'b0, row_i}) + {2'b0, col_i} + 4'd1;
    else if (col_i == 2'd0) operator_o = OP_CLR;
    else if (col_i == 2'd2) equal_o = 1'b1;
  end
endmodule

// File: rtl/input_control.sv
// input_control: keypad column scanner with LFSR-timed press/release debounce and key handshake.
module input_control
  import input_control_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] RowIn,
  output logic [3:0] ColOut,
  output logic       LFSRReset,
  input  logic       LFSRFlg,
  output logic       KeyRdy,
  input  logic       KeyRd,
  output logic [3:0] Number,
  output logic [2:0] Operator,
  output logic       EqualSign
);
  state_e     state_q, state_d;
  logic [3:0] col_q, col_d, num_q, num_d, dec_num;
  logic [2:0] op_q, op_d, dec_op;
  logic       eq_q, eq_d, dec_eq, lfsr_q, lfsr_d;
  logic       released, flg_ok;
  keypad_decode u_decode (
    .row_i      (low_idx(RowIn)),
    .col_i      (low_idx(col_q)),
    .number_o   (dec_num),
    .operator_o (dec_op),
    .equal_o    (dec_eq)
  );
  assign released = &RowIn;
  // The flag is stale in the cycle the timer is being restarted.
  assign flg_ok = LFSRFlg && !lfsr_q;
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    lfsr_d = 1'b0;
    num_d = num_q;
    op_d = op_q;
    eq_d = eq_q;
    case (state_q)
      SCAN:
        if (!released) begin
          state_d = DEB_PRESS;
          lfsr_d = 1'b1;
          num_d = dec_num;
          op_d = dec_op;
          eq_d = dec_eq;
        end else col_d = {col_q[0], col_q[3:1]};
      DEB_PRESS: state_d = flg_ok ? WAIT_REL : DEB_PRESS;
      WAIT_REL:
        if (released) begin
          state_d = DEB_REL;
          lfsr_d = 1'b1;
        end
      DEB_REL: state_d = flg_ok ? (released ? READY : WAIT_REL) : DEB_REL;
      READY: state_d = KeyRd ? SCAN : READY;
      default: state_d = SCAN;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= SCAN;
      col_q <= COL0;
      lfsr_q <= 1'b0;
      num_q <= '0;
      op_q <= OP_NONE;
      eq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      lfsr_q <= lfsr_d;
      num_q <= num_d;
      op_q <= op_d;
      eq_q <= eq_d;
    end
  end
  assign ColOut = col_q;
  assign LFSRReset = lfsr_q;
  assign KeyRdy = state_q == READY;
  assign Number = num_q;
  assign Operator = op_q;
  assign EqualSign = eq_q;
endmodule

// File: tb/tb_input_control.sv
// tb_input_control: directed keypad presses; expected keys queued at press time, checked when KeyRdy rises.
module tb_input_control;
  typedef struct packed {logic [3:0] num; logic [2:0] op; logic eq;} key_t;
  logic Clock = 1'b0, Reset = 1'b1, LFSRFlg = 1'b1, KeyRd = 1'b0;
  logic [3:0] RowIn = 4'hF;
  logic [3:0] ColOut, Number;
  logic [2:0] Operator;
  logic LFSRReset, KeyRdy, EqualSign;
  key_t exp_q[$];
  key_t mon_e;
  logic prev_rdy = 1'b0;
  int vectors = 0, misses = 0;

  input_control dut (
    .Clock(Clock), .Reset(Reset), .RowIn(RowIn), .ColOut(ColOut),
    .LFSRReset(LFSRReset), .LFSRFlg(LFSRFlg), .KeyRdy(KeyRdy), .KeyRd(KeyRd),
    .Number(Number), .Operator(Operator), .EqualSign(EqualSign)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (KeyRdy && !prev_rdy) begin
      if (exp_q.size() == 0) begin
        vectors++;
        misses++;
        $display("FAIL key: got %0h with no key expected", {Number, Operator, EqualSign});
      end else begin
        mon_e = exp_q.pop_front();
        check("key", 8'({Number, Operator, EqualSign}), 8'(mon_e));
      end
    end
    prev_rdy = KeyRdy;
  end

  task automatic press(input logic [3:0] col, input logic [3:0] rows, input key_t e);
    int n = 0;
    exp_q.push_back(e);
    @(negedge Clock);
    while (ColOut !== col && n < 8) begin
      @(negedge Clock);
      n++;
    end
    check("column reached", 8'(ColOut), 8'(col));
    RowIn = rows;
    @(negedge Clock);
    check("press pulse", 8'(LFSRReset), 8'd1);
  endtask

  task automatic wait_rdy(input int budget);
    int n = 0;
    while (!KeyRdy && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check("ready reached", 8'(KeyRdy), 8'd1);
  endtask

  task automatic ack();
    KeyRd = 1'b1;
    @(negedge Clock);
    KeyRd = 1'b0;
    check("ready drop", 8'(KeyRdy), 8'd0);
  endtask

  task automatic full_key(input logic [3:0] col, input logic [3:0] rows, input key_t e);
    press(col, rows, e);
    RowIn = 4'hF;
    wait_rdy(20);
    ack();
  endtask

  task automatic check_idle(input string name);
    check({name, " col"}, 8'(ColOut), 8'h7);
    check({name, " lfsr"}, 8'(LFSRReset), 8'd0);
    check({name, " rdy"}, 8'(KeyRdy), 8'd0);
    check({name, " outs"}, 8'({Number, Operator, EqualSign}), 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge Clock);
    check_idle("reset");
    Reset = 1'b0;
    press(4'b1011, 4'b0111, key_t'{4'd0, 3'd0, 1'b0});
    RowIn = 4'hF;
    @(negedge Clock);
    check("pulse one-shot", 8'(LFSRReset), 8'd0);
    wait_rdy(20);
    ack();
    full_key(4'b1110, 4'b1110, key_t'{4'd0, 3'd1, 1'b0});
    full_key(4'b1101, 4'b0111, key_t'{4'd0, 3'd0, 1'b1});
    full_key(4'b0111, 4'b0111, key_t'{4'd0, 3'd5, 1'b0});
    full_key(4'b1110, 4'b0110, key_t'{4'd0, 3'd4, 1'b0});
    full_key(4'b0111, 4'b1110, key_t'{4'd1, 3'd0, 1'b0});
    LFSRFlg = 1'b0;
    press(4'b1011, 4'b1101, key_t'{4'd5, 3'd0, 1'b0});
    RowIn = 4'hF;
    repeat (30) @(negedge Clock);
    check("stall no ready", 8'(KeyRdy), 8'd0);
    LFSRFlg = 1'b1;
    wait_rdy(20);
    ack();
    LFSRFlg = 1'b0;
    press(4'b1101, 4'b1011, key_t'{4'd9, 3'd0, 1'b0});
    LFSRFlg = 1'b1;
    repeat (3) @(negedge Clock);
    check("held no ready", 8'(KeyRdy), 8'd0);
    LFSRFlg = 1'b0;
    RowIn = 4'hF;
    @(negedge Clock);
    check("release pulse", 8'(LFSRReset), 8'd1);
    RowIn = 4'b1011;
    LFSRFlg = 1'b1;
    repeat (4) @(negedge Clock);
    check("bounce no ready", 8'(KeyRdy), 8'd0);
    check("bounce no pulse", 8'(LFSRReset), 8'd0);
    RowIn = 4'hF;
    @(negedge Clock);
    check("re-release pulse", 8'(LFSRReset), 8'd1);
    wait_rdy(20);
    ack();
    press(4'b1110, 4'b1011, key_t'{4'd0, 3'd3, 1'b0});
    RowIn = 4'hF;
    wait_rdy(20);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check_idle("ready reset");
    KeyRd = 1'b1;
    repeat (3) @(negedge Clock);
    KeyRd = 1'b0;
    check("stray ack", 8'(KeyRdy), 8'd0);
    check("queue drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule

// File: doc/input_control.md
INPUT_CONTROL -- requirements
Module: input_control

Interface
REQ-001 SHALL have port Clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port RowIn, input, 4 bits: keypad rows, active-low; row r is pressed when RowIn[3-r]=0; row 0 is the bottom row. RowIn is already synchronous to Clock; no internal synchronizer.
REQ-004 SHALL have port ColOut, output, 4 bits: keypad column drive, one-cold; column c is driven when ColOut[3-c]=0; column 0 is the leftmost column.
REQ-005 SHALL have port LFSRReset, output, 1 bit: one-cycle restart pulse to the external LFSR debounce timer.
REQ-006 SHALL have port LFSRFlg, input, 1 bit: debounce-interval-elapsed flag from the external timer.
REQ-007 SHALL have port KeyRdy, output, 1 bit: decoded key valid.
REQ-008 SHALL have port KeyRd, input, 1 bit: consumer acknowledge.
REQ-009 SHALL have port Number, output, 4 bits: digit value 0-9.
REQ-010 SHALL have port Operator, output, 3 bits: operator code.
REQ-011 SHALL have port EqualSign, output, 1 bit: '=' key indicator.

Function
REQ-012 SHALL use this key map (row, col0..col3):
- row 3 (top): 1 2 3 +
- row 2: 4 5 6 -
- row 1: 7 8 9 *
- row 0 (bottom): C 0 = /
REQ-013 SHALL use these Operator codes: 000 none/digit, 001 +, 010 -, 011 *, 100 /, 101 C (clear).
REQ-014 Decoded outputs SHALL be set as follows:
- Digit key: Number=value, Operator=000, EqualSign=0.
- Operator key: Number=0, Operator=code, EqualSign=0.
- '=' key: Number=0, Operator=000, EqualSign=1.
REQ-015 FSM states SHALL be SCAN, DEB_PRESS, WAIT_REL, DEB_REL, READY.
REQ-016 In SCAN, ColOut SHALL rotate one position per cycle, 0111 -> 1011 -> 1101 -> 1110 -> 0111.
REQ-017 In SCAN, when any RowIn bit is 0: latch the decode of the lowest-numbered low row with the currently driven column, freeze ColOut, pulse LFSRReset, and go to DEB_PRESS.
REQ-018 In DEB_PRESS, LFSRFlg is ignored in the LFSRReset cycle; on LFSRFlg=1 in any later cycle, go to WAIT_REL.
REQ-019 In WAIT_REL, when RowIn=1111: pulse LFSRReset and go to DEB_REL.
REQ-020 In DEB_REL, on qualified LFSRFlg=1:
- if RowIn=1111, go to READY;
- otherwise go back to WAIT_REL (bounce rejected).
REQ-021 In READY, KeyRdy SHALL be 1. On KeyRd=1, go to SCAN with KeyRdy=0 in the next cycle; ColOut stays frozen while in READY, so presses are ignored.
REQ-022 KeyRd outside READY SHALL be ignored.
REQ-023 Number, Operator and EqualSign SHALL hold their latched values until the next key is latched (REQ-017).
REQ-024 LFSRReset SHALL be high exactly one cycle per debounce entry and low otherwise.

Reset
REQ-025 On Reset=1 at a clock edge, the block SHALL set:
- state=SCAN, ColOut=0111;
- LFSRReset=0, KeyRdy=0;
- Number=0000, Operator=000, EqualSign=0.
REQ-026 Reset asserted in any state SHALL abort the operation and discard any pending key.

Structure
REQ-027 A shared package input_control_pkg SHALL hold the FSM state enum, the Operator code constants and the column one-cold constants.
REQ-028 The design SHALL have one sub-module, keypad_decode: combinational (row, col) -> Number, Operator, EqualSign.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, LFSRFlg=1, RowIn=0111 for 1 cycle while ColOut=1011 -> after release, KeyRdy=1, Number=0, Operator=000, EqualSign=0; KeyRd pulse -> KeyRdy=0 next cycle.
- RowIn=1110 with ColOut=1110 -> Operator=001 (+).
- RowIn=0111 with ColOut=1101 -> EqualSign=1.
- LFSRFlg held 0 -> KeyRdy stays 0 indefinitely; LFSRFlg=1 -> proceeds.
- RowIn bounces low during DEB_REL -> returns to WAIT_REL; KeyRdy only after a stable release.
- Reset during READY -> KeyRdy=0, ColOut=0111, all outputs zero.
